// File: rtl/dmem_responder.sv
// Data-memory responder: fixed-latency load/store slave with a byte-addressed array.
// Optional MISALIGN_CHECK_EN flags word accesses whose address bits [1:0] are non-zero.
module dmem_responder #(
  parameter int          ADDR_WIDTH = 17,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int         WORDS    = 2 ** (ADDR_WIDTH - 2);
  localparam bit         SINGLE   = (LATENCY == 1);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateE;

  stateE       state;
  logic [3:0]  counter;
  logic        latWrite, latByte;
  logic [31:0] latAddr, latWdata;

  logic                  accept, doAccess;
  logic                  accWrite, accByte;
  logic [31:0]           accAddr, accWdata;
  logic [31:0]           offset;
  logic [ADDR_WIDTH-3:0] wordIdx;
  logic [1:0]            lane;
  logic                  rangeErr, accErr;
  logic [3:0]            byteEn;
  logic [31:0]           wrData, memWord;
  logic [7:0]            readByte;
  logic                  memWe;

  logic [31:0] mem [WORDS];

  assign req_ready = (state != WAIT);
  assign accept    = req_valid & req_ready;

  // With a one-cycle latency the access happens on the accepting edge, so it
  // must use the live request instead of the latched copy.
  assign doAccess = SINGLE ? accept : (state == WAIT && counter == 4'd1);
  assign accWrite = SINGLE ? req_write : latWrite;
  assign accByte  = SINGLE ? req_byte  : latByte;
  assign accAddr  = SINGLE ? req_addr  : latAddr;
  assign accWdata = SINGLE ? req_wdata : latWdata;

  assign offset   = accAddr - BASE_ADDR;
  assign wordIdx  = offset[ADDR_WIDTH-1:2];
  assign lane     = offset[1:0];
  assign rangeErr = (offset >> ADDR_WIDTH) != 32'd0;

`ifdef MISALIGN_CHECK_EN
  assign accErr = rangeErr | (!accByte && accAddr[1:0] != 2'b00);
`else
  assign accErr = rangeErr;
`endif

  assign byteEn   = accByte ? (4'b0001 << lane) : 4'b1111;
  assign wrData   = accByte ? {4{accWdata[7:0]}} : accWdata;
  assign memWord  = mem[wordIdx];
  assign readByte = memWord[{lane, 3'b000} +: 8];
  assign memWe    = doAccess & accWrite & ~accErr;

  // NOTE: the array has no reset branch on purpose; resetting it would turn the
  // storage into a huge bank of reset flops instead of a RAM.
  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[wordIdx][8*i +: 8] <= wrData[8*i +: 8];
      end
    end
  end

  // NOTE: all registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      counter   <= 4'd0;
      latWrite  <= 1'b0;
      latByte   <= 1'b0;
      latAddr   <= 32'd0;
      latWdata  <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            latWrite <= req_write;
            latByte  <= req_byte;
            latAddr  <= req_addr;
            latWdata <= req_wdata;
            counter  <= CNT_INIT;
            if (SINGLE) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= WAIT;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          counter <= counter - 4'd1;
          if (counter == 4'd1) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            busy <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Response payload is captured only on the edge entering RESP and held otherwise.
      if (doAccess) begin
        rsp_err <= accErr;
        if (accErr || accWrite) rsp_rdata <= 32'd0;
        else if (accByte)       rsp_rdata <= {24'd0, readByte};
        else                    rsp_rdata <= memWord;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance at LATENCY=2, one at LATENCY=1.
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int          AW   = 17;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } expT;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        reqWrite, reqByte;
  logic [31:0] reqAddr, reqWdata;
  int          sel;

  logic        valid0, ready0, rspValid0, rspErr0, busy0;
  logic        valid1, ready1, rspValid1, rspErr1, busy1;
  logic [31:0] rdata0, rdata1;

  expT         q0[$];
  expT         q1[$];
  expT         e0, e1;
  logic [7:0]  model [int unsigned];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          busyCnt0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign valid0 = reqValid && (sel == 0);
  assign valid1 = reqValid && (sel == 1);

  dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(2), .BASE_ADDR(BASE)) dut0 (
    .clk(clk), .reset(reset), .req_valid(valid0), .req_ready(ready0),
    .req_write(reqWrite), .req_byte(reqByte), .req_addr(reqAddr), .req_wdata(reqWdata),
    .rsp_valid(rspValid0), .rsp_rdata(rdata0), .rsp_err(rspErr0), .busy(busy0));

  dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(1), .BASE_ADDR(BASE)) dut1 (
    .clk(clk), .reset(reset), .req_valid(valid1), .req_ready(ready1),
    .req_write(reqWrite), .req_byte(reqByte), .req_addr(reqAddr), .req_wdata(reqWdata),
    .rsp_valid(rspValid1), .rsp_rdata(rdata1), .rsp_err(rspErr1), .busy(busy1));

  // Response monitor: every strobe must match the oldest expectation, including its cycle.
  always @(negedge clk) begin
    if (busy0) busyCnt0++;
    if (rspValid0) begin
      vectors++;
      if (q0.size() == 0) begin
        miscompares++;
        $display("FAIL rsp0_unexpected: got rdata=%h err=%b at cycle %0d, expected no response", rdata0, rspErr0, cyc);
      end else begin
        e0 = q0.pop_front();
        if (rdata0 !== e0.rdata || rspErr0 !== e0.err || cyc !== e0.due) begin
          miscompares++;
          $display("FAIL rsp0: got rdata=%h err=%b cycle=%0d, expected rdata=%h err=%b cycle=%0d",
                   rdata0, rspErr0, cyc, e0.rdata, e0.err, e0.due);
        end
      end
    end
    if (rspValid1) begin
      vectors++;
      if (q1.size() == 0) begin
        miscompares++;
        $display("FAIL rsp1_unexpected: got rdata=%h err=%b at cycle %0d, expected no response", rdata1, rspErr1, cyc);
      end else begin
        e1 = q1.pop_front();
        if (rdata1 !== e1.rdata || rspErr1 !== e1.err || cyc !== e1.due) begin
          miscompares++;
          $display("FAIL rsp1: got rdata=%h err=%b cycle=%0d, expected rdata=%h err=%b cycle=%0d",
                   rdata1, rspErr1, cyc, e1.rdata, e1.err, e1.due);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // Drives one request, computes its expected response from the byte model and
  // queues it once the selected DUT shows req_ready. Leaves req_valid asserted.
  task automatic issue(input bit w, input bit b, input logic [31:0] a, input logic [31:0] d,
                       output int acceptCyc);
    logic [31:0] off, wb, rd;
    bit          err, done;
    expT         e;
    reqWrite = w; reqByte = b; reqAddr = a; reqWdata = d; reqValid = 1'b1;
    off = a - BASE;
    wb  = {off[31:2], 2'b00};
    err = (off >= (32'd1 << AW));
`ifdef MISALIGN_CHECK_EN
    if (!b && off[1:0] != 2'b00) err = 1'b1;
`endif
    rd = 32'd0;
    if (!err) begin
      if (w) begin
        if (b) model[off] = d[7:0];
        else for (int i = 0; i < 4; i++) model[wb + i] = d[8*i +: 8];
      end else if (b) begin
        rd = {24'd0, model[off]};
      end else begin
        rd = {model[wb + 3], model[wb + 2], model[wb + 1], model[wb]};
      end
    end
    e.rdata = rd; e.err = err;
    done = 1'b0; acceptCyc = -1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if ((sel == 0) ? ready0 : ready1) begin
        e.due = cyc + ((sel == 0) ? 2 : 1);
        acceptCyc = cyc;
        if (sel == 0) q0.push_back(e); else q1.push_back(e);
        done = 1'b1;
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL accept_timeout: req_ready stayed 0, expected acceptance of addr %h", a);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    reqValid = 1'b0;
    for (int i = 0; i < 40 && (q0.size() + q1.size()) != 0; i++) @(posedge clk);
    vectors++;
    if ((q0.size() + q1.size()) != 0) begin
      miscompares++;
      $display("FAIL drain: %0d responses outstanding, expected 0", q0.size() + q1.size());
      q0.delete(); q1.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if (ready0 !== 1'b1 || rspValid0 !== 1'b0 || rdata0 !== 32'd0 || rspErr0 !== 1'b0 || busy0 !== 1'b0 ||
        ready1 !== 1'b1 || rspValid1 !== 1'b0 || rdata1 !== 32'd0 || rspErr1 !== 1'b0 || busy1 !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got ready=%b/%b valid=%b/%b rdata=%h/%h err=%b/%b busy=%b/%b, expected 1 0 0 0 0",
               tag, ready0, ready1, rspValid0, rspValid1, rdata0, rdata1, rspErr0, rspErr1, busy0, busy1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; reqValid = 1'b0; sel = 0;
    reqWrite = 1'b0; reqByte = 1'b0; reqAddr = 32'd0; reqWdata = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_values");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_word();
    int c;
    sel = 0;
    busyCnt0 = 0;
    issue(1'b1, 1'b0, 32'h0001_0010, 32'hDEAD_BEEF, c);
    drain();
    vectors++;
    if (busyCnt0 !== 1) begin
      miscompares++;
      $display("FAIL busy_store: got %0d busy cycles, expected 1", busyCnt0);
    end
    busyCnt0 = 0;
    issue(1'b0, 1'b0, 32'h0001_0010, 32'h0, c);
    drain();
    vectors++;
    if (busyCnt0 !== 1) begin
      miscompares++;
      $display("FAIL busy_load: got %0d busy cycles, expected 1", busyCnt0);
    end
  endtask

  task automatic test_byte();
    int c;
    sel = 0;
    issue(1'b1, 1'b0, 32'h0001_0010, 32'h0000_0000, c);
    issue(1'b1, 1'b1, 32'h0001_0013, 32'hFFFF_FFA5, c);
    issue(1'b0, 1'b0, 32'h0001_0010, 32'h0, c);
    issue(1'b0, 1'b1, 32'h0001_0013, 32'h0, c);
    issue(1'b0, 1'b1, 32'h0001_0010, 32'h0, c);
    drain();
  endtask

  task automatic test_errors();
    int c;
    sel = 0;
    issue(1'b1, 1'b0, 32'h0001_0000, 32'hCAFE_F00D, c);
    issue(1'b0, 1'b0, 32'h0000_0004, 32'h0, c);
    issue(1'b1, 1'b0, BASE + (32'd1 << AW), 32'h5555_5555, c);
    issue(1'b0, 1'b0, 32'h0001_0000, 32'h0, c);
    issue(1'b0, 1'b1, 32'h0000_FFFF, 32'h0, c);
    issue(1'b1, 1'b0, 32'h0002_FFFC, 32'h89AB_CDEF, c);
    issue(1'b0, 1'b0, 32'h0002_FFFC, 32'h0, c);
    drain();
  endtask

  task automatic test_back_to_back();
    int c0, c1, c2, c3;
    sel = 1;
    issue(1'b1, 1'b0, 32'h0001_0040, 32'h1357_2468, c0);
    issue(1'b0, 1'b0, 32'h0001_0040, 32'h0, c1);
    issue(1'b1, 1'b1, 32'h0001_0041, 32'h0000_00C3, c2);
    issue(1'b0, 1'b0, 32'h0001_0040, 32'h0, c3);
    drain();
    vectors++;
    if (c1 - c0 !== 1 || c2 - c1 !== 1 || c3 - c2 !== 1) begin
      miscompares++;
      $display("FAIL b2b_accepts: got accept cycles %0d %0d %0d %0d, expected consecutive", c0, c1, c2, c3);
    end
  endtask

  task automatic test_reset_mid();
    int  c;
    bit  seen;
    sel = 0;
    issue(1'b1, 1'b0, 32'h0001_0020, 32'h1234_5678, c);
    issue(1'b0, 1'b0, 32'h0001_0020, 32'h0, c);
    drain();
    // Store that will be aborted by reset while in WAIT; the model is left untouched.
    reqWrite = 1'b1; reqByte = 1'b0; reqAddr = 32'h0001_0020; reqWdata = 32'h1111_1111; reqValid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = ready0;
    end
    @(posedge clk); #1;
    reqValid = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy0 !== 1'b1 || ready0 !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_wait: got busy=%b ready=%b, expected busy=1 ready=0", busy0, ready0);
    end
    #1 reset = 1'b0;
    #1 check_reset_outputs("reset_mid_values");
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    issue(1'b0, 1'b0, 32'h0001_0020, 32'h0, c);
    drain();
  endtask

  task automatic test_misalign();
    int c;
    sel = 0;
    issue(1'b0, 1'b0, 32'h0001_0002, 32'h0, c);
    issue(1'b0, 1'b1, 32'h0001_0002, 32'h0, c);
    drain();
    sel = 1;
    issue(1'b0, 1'b0, 32'h0001_0043, 32'h0, c);
    drain();
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined core's memory stage: the slave end of the load/store request interface issued by the Memory stage. It accepts one request at a time, models a fixed multi-cycle access latency, and performs word/byte stores and word/zero-extended-byte loads on an internal byte-addressed array. It returns a single-cycle response and drives a stall request the hazard unit uses to hold the pipeline while an access is outstanding.

## Interface
Parameters:
- ADDR_WIDTH, 17, byte-address width of the array (size 2^ADDR_WIDTH bytes)
- LATENCY, 2, cycles from request acceptance to response; legal range 1..15
- BASE_ADDR, 32'h0001_0000, first byte address mapped to the array

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept; combinational from state
- req_write  input  1  1 = store, 0 = load
- req_byte  input  1  1 = byte access, 0 = word access
- req_addr  input  32  byte address
- req_wdata  input  32  store data; byte stores use bits [7:0]
- rsp_valid  output  1  one-cycle response strobe
- rsp_rdata  output  32  load data; 0 for stores and errors
- rsp_err  output  1  access error, qualified by rsp_valid
- busy  output  1  stall request to hazard unit

## Operation
- States: IDLE, WAIT, RESP.
- req_ready = 1 in IDLE and RESP, 0 in WAIT.
- Accept = req_valid & req_ready. On accept, latch write, byte, addr and wdata; load counter with LATENCY-1.
- LATENCY==1: accept goes directly to RESP. Otherwise accept goes to WAIT.
- WAIT: decrement counter each cycle; at counter==1 go to RESP.
- RESP: rsp_valid=1 for exactly this cycle. Accept here follows the same rules as IDLE; otherwise return to IDLE.
- Access is performed on the edge entering RESP:
  - store: write to array;
  - load: capture rsp_rdata.
  - A load accepted in RESP after a store to the same address returns the new data.
- Offset = req_addr - BASE_ADDR, 32-bit unsigned. Offset >= 2^ADDR_WIDTH: rsp_err=1, rsp_rdata=0, store dropped.
- Word access uses offset with bits [1:0] cleared; little-endian.
- Byte load returns {24'b0, byte}. Byte store writes lane offset[1:0] only.
- busy = 1 in WAIT only; registered.
- rsp_rdata/rsp_err hold their last values when rsp_valid=0.
- Array contents are not reset.

## Timing
- Accept in cycle N gives rsp_valid in cycle N+LATENCY. Maximum throughput is one request per LATENCY cycles.
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 0, counter 0. req_ready is 1 during reset.
- Reset asserted mid-operation: pending request discarded and pending store not performed; no response is issued.
- req_valid while req_ready=0: ignored. The requester must hold the request until it is accepted.
- No backpressure on the response: it is delivered whether or not it is consumed.

## Configuration
- MISALIGN_CHECK_EN defined: a word access with req_addr[1:0]!=0 responds with rsp_err=1 and rsp_rdata=0, and a store is dropped. Error timing is identical to a normal access.
- MISALIGN_CHECK_EN undefined: address bits [1:0] are silently ignored for word accesses; rsp_err reflects range errors only.

## Test plan
- Reset, then word store 32'hDEADBEEF to 32'h0001_0010, then word load from the same address (LATENCY=2) -> store rsp_valid 2 cycles after accept with rsp_err=0; load returns 32'hDEADBEEF; busy high exactly 1 cycle per access.
- Byte store 8'hA5 to 32'h0001_0013 over word 32'h0; word load -> 32'hA500_0000. Byte load from 32'h0001_0013 -> 32'h0000_00A5.
- Load from 32'h0000_0004, and store to BASE_ADDR+2^ADDR_WIDTH -> rsp_err=1, rsp_rdata=0, array unchanged on readback.
- LATENCY=1, requests held valid back-to-back (store then load, same address) -> accepts on consecutive cycles; rsp_valid high every cycle; load sees stored data.
- Reset asserted during WAIT of a store -> no rsp_valid; later load of that address returns the old value; all outputs at reset values.
- With MISALIGN_CHECK_EN, word load from 32'h0001_0002 -> rsp_err=1, rdata=0. Without the macro -> returns the word at 32'h0001_0000, rsp_err=0.
